rom_dl_ctrl: RTL

ROM_DL_CTRL -- requirements
Module: rom_dl_ctrl

---
 rtl/rom_dl_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/rom_dl_ctrl.sv
// rom_dl_ctrl
// Accepts a host byte download into the ROM bank, registers each write with
// its region code, and holds the system in reset until a complete and
// in-range image has been loaded. A short, oversize or out-of-range image
// leaves the system held in reset and raises load_err.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no valid image; waiting for a download with the ROM index
// LOAD  | download in progress; accepting and forwarding byte writes
// CHECK | download ended; verifying byte count, high-water and range
// HOLD  | image good; holding system reset for HOLD_CYC cycles
// RUN   | image loaded and system released from reset

module rom_dl_ctrl #(
    parameter int unsigned ROM_LEN   = 'h1C720,
    parameter int unsigned HOLD_CYC  = 16,
    parameter logic [7:0]  ROM_INDEX = 8'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dl_active,
    input  logic [7:0]  dl_index,
    input  logic        dl_wr,
    input  logic [24:0] dl_addr,
    input  logic [7:0]  dl_data,
    output logic        wr_en,
    output logic [24:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [4:0]  region,
    output logic        sys_reset,
    output logic        load_done,
    output logic        load_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_HOLD  = 3'd3,
        S_RUN   = 3'd4
    } state_t;

    localparam logic [24:0] ROM_LEN_C = 25'(ROM_LEN);
    localparam logic [24:0] LAST_ADDR = 25'(ROM_LEN - 1);

    // The hold timer is a down-counter loaded with HOLD_CYC-1, so HOLD lasts
    // exactly HOLD_CYC cycles; HOLD_CYC of 0 or 1 both give a single cycle.
    localparam int unsigned HOLD_W = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD =
        (HOLD_CYC > 0) ? HOLD_W'(HOLD_CYC - 1) : '0;

    state_t              state;
    state_t              state_next;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [24:0]         byte_cnt;
    logic [24:0]         high_water;
    logic                range_err;

    logic                index_match;
    logic                dl_start;
    logic                wr_accept;
    logic                addr_in_range;
    logic                check_err;
    logic                enter_load;

    // Address-to-region map of the ROM bank; anything past the image is 31.
    function automatic logic [4:0] region_of(input logic [24:0] a);
        logic [4:0] r;
        r = 5'd31;
        if      (a < 25'h04000) r = 5'd0;
        else if (a < 25'h08000) r = 5'd1;
        else if (a < 25'h0A000) r = 5'd2;
        else if (a < 25'h0C000) r = 5'd3;
        else if (a < 25'h0E000) r = 5'd4;
        else if (a < 25'h10000) r = 5'd5;
        else if (a < 25'h12000) r = 5'd6;
        else if (a < 25'h14000) r = 5'd7;
        else if (a < 25'h16000) r = 5'd8;
        else if (a < 25'h18000) r = 5'd9;
        else if (a < 25'h1A000) r = 5'd10;
        else if (a < 25'h1C000) r = 5'd11;
        else if (a < 25'h1C100) r = 5'd12;
        else if (a < 25'h1C200) r = 5'd13;
        else if (a < 25'h1C300) r = 5'd14;
        else if (a < 25'h1C400) r = 5'd15;
        else if (a < 25'h1C500) r = 5'd16;
        else if (a < 25'h1C600) r = 5'd17;
        else if (a < 25'h1C700) r = 5'd18;
        else if (a < 25'h1C720) r = 5'd19;
        return r;
    endfunction

    // Write qualification and image-check decode.
    always_comb begin
        index_match   = (dl_index == ROM_INDEX);
        dl_start      = dl_active && index_match;
        // dl_active is deliberately not required: the byte written in the
        // same cycle the download ends still belongs to the image.
        wr_accept     = (state == S_LOAD) && dl_wr && index_match;
        addr_in_range = (dl_addr < ROM_LEN_C);
        check_err     = (byte_cnt != ROM_LEN_C) || (high_water != LAST_ADDR) ||
                        range_err;
        enter_load    = (state_next == S_LOAD) && (state != S_LOAD);
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (dl_start) state_next = S_LOAD;
            end
            S_LOAD: begin
                if (!dl_active) state_next = S_CHECK;
            end
            S_CHECK: begin
                if (check_err) state_next = S_IDLE;
                else           state_next = S_HOLD;
            end
            S_HOLD: begin
                if (dl_start)            state_next = S_LOAD;
                else if (hold_cnt == '0) state_next = S_RUN;
            end
            S_RUN: begin
                if (dl_start) state_next = S_LOAD;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Reset-hold timer, loaded as CHECK passes and counted down in HOLD.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (state == S_CHECK) begin
            hold_cnt <= HOLD_LOAD;
        end else if ((state == S_HOLD) && (hold_cnt != '0)) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end

    // Image bookkeeping: saturating byte count, high-water address, range flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt   <= '0;
            high_water <= '0;
            range_err  <= 1'b0;
        end else if (enter_load) begin
            byte_cnt   <= '0;
            high_water <= '0;
            range_err  <= 1'b0;
        end else if (wr_accept) begin
            if (byte_cnt != '1)        byte_cnt   <= byte_cnt + 1'b1;
            if (dl_addr > high_water)  high_water <= dl_addr;
            if (!addr_in_range)        range_err  <= 1'b1;
        end
    end

    // Registered write port to the ROM bank; out-of-range bytes never reach it.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            region  <= '0;
        end else begin
            wr_en <= wr_accept && addr_in_range;
            if (wr_accept && addr_in_range) begin
                wr_addr <= dl_addr;
                wr_data <= dl_data;
                region  <= region_of(dl_addr);
            end
        end
    end

    // Status outputs follow the state being entered so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            sys_reset <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            sys_reset <= (state_next != S_RUN);
            load_done <= (state_next == S_RUN);
            if (enter_load) begin
                load_err <= 1'b0;
            end else if ((state == S_CHECK) && check_err) begin
                load_err <= 1'b1;
            end
        end
    end

endmodule
